// File: rtl/interconnect_pkg.sv
// Shared definitions for the multilayer AHB interconnect: HTRANS encodings and
// the per-slave arbiter state type.
package interconnect_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_OWNED
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational winner picker: round-robin starting after i_ptr, or
// lowest-index-first when ARB_FIXED_PRIO_EN is defined (pointer port removed).
module rr_picker #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 1
) (
    input  logic [N-1:0] i_req,
`ifndef ARB_FIXED_PRIO_EN
    input  logic [W-1:0] i_ptr,
`endif
    output logic [N-1:0] o_onehot,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    always_comb begin
        int unsigned cand;
        cand     = 0;
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < N; i++) begin
            cand = i;
            if (!o_any && i_req[cand]) begin
                o_any          = 1'b1;
                o_onehot[cand] = 1'b1;
                o_idx          = W'(cand);
            end
        end
`else
        // Search starts one past the pointer, so the pointer's own master is last.
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[cand]) begin
                o_any          = 1'b1;
                o_onehot[cand] = 1'b1;
                o_idx          = W'(cand);
            end
        end
`endif
    end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: grants one master at a time, holds across bursts and
// locked sequences, and tracks the data phase. Macro: ARB_FIXED_PRIO_EN.
module ahb_slave_arbiter
    import interconnect_pkg::*;
#(
    parameter  int unsigned NUM_MASTERS = 2,
    localparam int unsigned MW          = $clog2(NUM_MASTERS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_MASTERS-1:0]   i_hsel,
    input  logic [2*NUM_MASTERS-1:0] i_htrans,
    input  logic [NUM_MASTERS-1:0]   i_hmastlock,
    input  logic                     i_hready,
    output logic [NUM_MASTERS-1:0]   o_grant,
    output logic [MW-1:0]            o_addr_sel,
    output logic                     o_addr_valid,
    output logic [MW-1:0]            o_data_sel,
    output logic                     o_data_valid,
    output logic [NUM_MASTERS-1:0]   o_wait
);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          addr_sel_q, addr_sel_d;
    logic [MW-1:0]          data_sel_q, data_sel_d;
    logic                   data_valid_q, data_valid_d;
`ifndef ARB_FIXED_PRIO_EN
    logic [MW-1:0]          rr_ptr_q, rr_ptr_d;
`endif

    logic [NUM_MASTERS-1:0] req;
    logic [1:0]             own_trans;
    logic                   own_hsel;
    logic                   own_lock;
    logic                   cont;
    logic                   addr_valid;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [MW-1:0]          pick_idx;
    logic                   pick_any;

    always_comb begin
        req = '0;
        for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
            req[m] = i_hsel[m] & i_htrans[2*m+1];
        end
    end

    assign own_trans  = i_htrans[{addr_sel_q, 1'b0} +: 2];
    assign own_hsel   = i_hsel[addr_sel_q];
    assign own_lock   = i_hmastlock[addr_sel_q];
    assign cont       = (state_q == ST_OWNED) &&
                        ((own_hsel && (own_trans == HTRANS_BUSY || own_trans == HTRANS_SEQ)) ||
                         own_lock);
    assign addr_valid = (state_q == ST_OWNED) && req[addr_sel_q];

    rr_picker #(
        .N (NUM_MASTERS),
        .W (MW)
    ) u_picker (
        .i_req    (req),
`ifndef ARB_FIXED_PRIO_EN
        .i_ptr    (rr_ptr_q),
`endif
        .o_onehot (pick_onehot),
        .o_idx    (pick_idx),
        .o_any    (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        addr_sel_d   = addr_sel_q;
        data_sel_d   = data_sel_q;
        data_valid_d = data_valid_q;
`ifndef ARB_FIXED_PRIO_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        if (i_hready) begin
            data_valid_d = addr_valid;
            data_sel_d   = addr_sel_q;
            // Owner's burst ending and a new winner loading share one edge: no idle gap.
            if (!cont) begin
                if (pick_any) begin
                    state_d    = ST_OWNED;
                    grant_d    = pick_onehot;
                    addr_sel_d = pick_idx;
`ifndef ARB_FIXED_PRIO_EN
                    rr_ptr_d   = pick_idx;
`endif
                end else begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            addr_sel_q   <= '0;
            data_sel_q   <= '0;
            data_valid_q <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr_q     <= MW'(NUM_MASTERS - 1);
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            addr_sel_q   <= addr_sel_d;
            data_sel_q   <= data_sel_d;
            data_valid_q <= data_valid_d;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    assign o_grant      = grant_q;
    assign o_addr_sel   = addr_sel_q;
    assign o_addr_valid = addr_valid;
    assign o_data_sel   = data_sel_q;
    assign o_data_valid = data_valid_q;
    assign o_wait       = req & ~grant_q;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Scoreboard bench for ahb_slave_arbiter: directed scenarios plus random traffic
// checked against a transaction-level arbitration model.
module tb_ahb_slave_arbiter;

    localparam int NM = 2;
    localparam int MW = 1;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NS   = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    logic              clk = 1'b0;
    logic              i_rst;
    logic [NM-1:0]     i_hsel;
    logic [2*NM-1:0]   i_htrans;
    logic [NM-1:0]     i_hmastlock;
    logic              i_hready;
    logic [NM-1:0]     o_grant;
    logic [MW-1:0]     o_addr_sel;
    logic              o_addr_valid;
    logic [MW-1:0]     o_data_sel;
    logic              o_data_valid;
    logic [NM-1:0]     o_wait;

    always #5 clk = ~clk;

    ahb_slave_arbiter #(.NUM_MASTERS(NM)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_hsel       (i_hsel),
        .i_htrans     (i_htrans),
        .i_hmastlock  (i_hmastlock),
        .i_hready     (i_hready),
        .o_grant      (o_grant),
        .o_addr_sel   (o_addr_sel),
        .o_addr_valid (o_addr_valid),
        .o_data_sel   (o_data_sel),
        .o_data_valid (o_data_valid),
        .o_wait       (o_wait)
    );

    typedef struct packed {
        logic [NM-1:0] grant;
        logic [MW-1:0] asel;
        logic          av;
        logic [MW-1:0] dsel;
        logic          dv;
        logic [NM-1:0] wt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: owner (-1 = nobody), last winner, data-phase owner.
    int              owner, sel, last, dsel;
    bit              dvalid;
    logic [NM-1:0]   m_hsel;
    logic [2*NM-1:0] m_tr;
    logic [NM-1:0]   m_lock;
    logic            m_rdy;
    logic            m_rst;

    function automatic logic [1:0] trans_of(int m);
        return m_tr[2*m +: 2];
    endfunction

    function automatic bit wants(int m);
        return m_hsel[m] && (trans_of(m) == T_NS || trans_of(m) == T_SEQ);
    endfunction

    function automatic bit model_av();
        return owner >= 0 && wants(owner);
    endfunction

    task automatic model_reset();
        owner  = -1;
        sel    = 0;
        last   = NM - 1;
        dsel   = 0;
        dvalid = 0;
    endtask

    task automatic model_advance();
        bit keep;
        int w;
        w      = -1;
        dvalid = model_av();
        dsel   = sel;
        keep   = owner >= 0 &&
                 ((m_hsel[owner] && (trans_of(owner) == T_BUSY || trans_of(owner) == T_SEQ)) ||
                  m_lock[owner]);
        if (!keep) begin
            for (int k = 1; k <= NM; k++) begin
                if (w < 0 && wants((last + k) % NM)) w = (last + k) % NM;
            end
            if (w >= 0) begin
                owner = w;
                sel   = w;
                last  = w;
            end else begin
                owner = -1;
            end
        end
    endtask

    function automatic exp_t model_expect();
        exp_t e;
        e.grant = '0;
        e.wt    = '0;
        if (owner >= 0) e.grant[owner] = 1'b1;
        e.asel  = MW'(sel);
        e.av    = model_av();
        e.dsel  = MW'(dsel);
        e.dv    = dvalid;
        for (int m = 0; m < NM; m++) e.wt[m] = wants(m) && (owner != m);
        return e;
    endfunction

    function automatic logic [2*NM-1:0] tr2(logic [1:0] t0, logic [1:0] t1);
        return {t1, t0};
    endfunction

    // One clock: let the edge happen, advance the model, drive new inputs, queue expectation.
    task automatic step(input logic [NM-1:0] hs, input logic [2*NM-1:0] tr,
                        input logic [NM-1:0] lk, input logic rdy, input logic rst);
        @(posedge clk);
        if (!m_rst && m_rdy) model_advance();
        #1;
        i_hsel = hs; i_htrans = tr; i_hmastlock = lk; i_hready = rdy; i_rst = rst;
        m_hsel = hs; m_tr = tr; m_lock = lk; m_rdy = rdy; m_rst = rst;
        if (rst) model_reset();
        sb.push_back(model_expect());
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("grant",      int'(o_grant),      int'(e.grant));
                check("addr_sel",   int'(o_addr_sel),   int'(e.asel));
                check("addr_valid", int'(o_addr_valid), int'(e.av));
                check("data_sel",   int'(o_data_sel),   int'(e.dsel));
                check("data_valid", int'(o_data_valid), int'(e.dv));
                check("wait",       int'(o_wait),       int'(e.wt));
            end
        end
    end

    initial begin : stim
        logic [2*NM-1:0] rtr;
        i_rst = 1'b1; i_hsel = '0; i_htrans = '0; i_hmastlock = '0; i_hready = 1'b1;
        m_rst = 1'b1; m_hsel = '0; m_tr = '0; m_lock = '0; m_rdy = 1'b1;
        model_reset();

        step(2'b00, '0, '0, 1'b1, 1'b1);
        step(2'b00, '0, '0, 1'b1, 1'b1);
        // M0 single NONSEQ after reset
        step(2'b01, tr2(T_NS, T_IDLE), '0, 1'b1, 1'b0);
        step(2'b01, tr2(T_NS, T_IDLE), '0, 1'b1, 1'b0);
        step(2'b00, '0, '0, 1'b1, 1'b0);
        step(2'b00, '0, '0, 1'b1, 1'b0);
        // Both masters issuing repeated single transfers
        repeat (6) step(2'b11, tr2(T_NS, T_NS), '0, 1'b1, 1'b0);
        step(2'b00, '0, '0, 1'b1, 1'b0);
        // M0 INCR4 while M1 requests
        step(2'b11, tr2(T_NS, T_NS), '0, 1'b1, 1'b0);
        step(2'b11, tr2(T_NS, T_NS), '0, 1'b1, 1'b0);
        repeat (3) step(2'b11, tr2(T_SEQ, T_NS), '0, 1'b1, 1'b0);
        step(2'b10, tr2(T_IDLE, T_NS), '0, 1'b1, 1'b0);
        step(2'b10, tr2(T_IDLE, T_NS), '0, 1'b1, 1'b0);
        step(2'b00, '0, '0, 1'b1, 1'b0);
        // M1 locked, issuing IDLE, M0 requesting until lock drops
        step(2'b10, tr2(T_IDLE, T_NS), 2'b10, 1'b1, 1'b0);
        repeat (4) step(2'b11, tr2(T_NS, T_IDLE), 2'b10, 1'b1, 1'b0);
        repeat (3) step(2'b11, tr2(T_NS, T_IDLE), 2'b00, 1'b1, 1'b0);
        // Owner stalled by i_hready=0 for 3 cycles while M1 requests
        step(2'b11, tr2(T_NS, T_NS), '0, 1'b1, 1'b0);
        repeat (3) step(2'b11, tr2(T_NS, T_NS), '0, 1'b0, 1'b0);
        repeat (3) step(2'b11, tr2(T_NS, T_NS), '0, 1'b1, 1'b0);
        // Reset mid-burst
        step(2'b11, tr2(T_SEQ, T_NS), '0, 1'b1, 1'b0);
        step(2'b11, tr2(T_SEQ, T_NS), '0, 1'b1, 1'b1);
        step(2'b11, tr2(T_NS, T_NS), '0, 1'b1, 1'b0);
        step(2'b11, tr2(T_NS, T_NS), '0, 1'b1, 1'b0);
        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rtr = (2*NM)'($urandom);
            step((NM)'($urandom),
                 rtr,
                 ($urandom_range(0, 7) == 0) ? (NM)'($urandom) : '0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 199) == 0);
        end

        repeat (5) begin
            if (sb.size() > 0) @(negedge clk);
        end
        #1;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
